// File: rtl/pc_pkg.sv
// Shared types and helpers for the LEGv8 program-counter sequencer.
package pc_pkg;

   typedef enum logic [1:0] {StBoot, StRun, StFault} pc_state_e;

   localparam int unsigned INSTR_BYTES = 4;
   localparam int unsigned INSTR_SHIFT = 2;
   // Widest address the offset helper supports.
   localparam int unsigned MAX_W = 128;

   // Sign-extends an off_w-bit word offset (held zero-extended in off) and scales to bytes.
   function automatic logic [MAX_W-1:0] sext_shift(input logic [MAX_W-1:0] off,
                                                   input int unsigned   off_w);
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] ext;
      logic             sign;
      mask = {MAX_W{1'b1}} << off_w;
      sign = off[7'(off_w - 1)];
      ext  = sign ? (off | mask) : (off & ~mask);
      return ext << INSTR_SHIFT;
   endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational branch resolution: taken decision, redirect target and alignment check.
module pc_target_calc
   import pc_pkg::*;
#(
   parameter int unsigned ADDR_W   = 64,
   parameter int unsigned OFFSET_W = 26
) (
   input  logic                br_valid_i,
   input  logic                br_uncond_i,
   input  logic                br_cond_i,
   input  logic                br_reg_i,
   input  logic                negate_i,
   input  logic                zero_flag_i,
   input  logic [OFFSET_W-1:0] br_offset_i,
   input  logic [ADDR_W-1:0]   br_pc_i,
   input  logic [ADDR_W-1:0]   br_target_reg_i,
   output logic                taken_o,
   output logic [ADDR_W-1:0]   target_o,
   output logic                misaligned_o
);

   logic [ADDR_W-1:0] off_bytes;
   logic              cond_met;

   assign off_bytes    = ADDR_W'(sext_shift(MAX_W'(br_offset_i), OFFSET_W));
   assign cond_met     = br_cond_i & (zero_flag_i ^ negate_i);
   assign taken_o      = br_valid_i & (br_uncond_i | br_reg_i | cond_met);
   // Register target wins when several type bits are set; PC-relative sum wraps silently.
   assign target_o     = br_reg_i ? br_target_reg_i : br_pc_i + off_bytes;
   assign misaligned_o = target_o[1:0] != 2'b00;

endmodule

// File: rtl/pc_sequencer.sv
// Registered PC and fetch sequencer with branch redirect, BL link and sticky misalignment fault.
// Optional performance counters are built when PC_PERF_COUNTERS_EN is defined.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 64,
   parameter int unsigned       OFFSET_W  = 26,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                fetch_valid_o,
   input  logic                fetch_ready_i,
   output logic [ADDR_W-1:0]   fetch_addr_o,
   input  logic                stall_i,
   input  logic                br_valid_i,
   input  logic                br_uncond_i,
   input  logic                br_cond_i,
   input  logic                br_reg_i,
   input  logic                br_link_i,
   input  logic                negate_i,
   input  logic                zero_flag_i,
   input  logic [OFFSET_W-1:0] br_offset_i,
   input  logic [ADDR_W-1:0]   br_pc_i,
   input  logic [ADDR_W-1:0]   br_target_reg_i,
   output logic                link_valid_o,
   output logic [ADDR_W-1:0]   link_addr_o,
   output logic                fault_o,
   output logic [ADDR_W-1:0]   fault_addr_o,
   output logic [31:0]         fetch_count_o,
   output logic [31:0]         redirect_count_o
);

   pc_state_e         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              fault_q, fault_d;
   logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
   logic              link_valid_q, link_valid_d;
   logic [ADDR_W-1:0] link_addr_q, link_addr_d;

   logic              taken;
   logic              misaligned;
   logic [ADDR_W-1:0] target;

   pc_target_calc #(
      .ADDR_W   (ADDR_W),
      .OFFSET_W (OFFSET_W)
   ) u_target_calc (
      .br_valid_i      (br_valid_i),
      .br_uncond_i     (br_uncond_i),
      .br_cond_i       (br_cond_i),
      .br_reg_i        (br_reg_i),
      .negate_i        (negate_i),
      .zero_flag_i     (zero_flag_i),
      .br_offset_i     (br_offset_i),
      .br_pc_i         (br_pc_i),
      .br_target_reg_i (br_target_reg_i),
      .taken_o         (taken),
      .target_o        (target),
      .misaligned_o    (misaligned)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StBoot;
         pc_q         <= RESET_VEC;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
         link_valid_q <= link_valid_d;
         link_addr_q  <= link_addr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      link_valid_d = 1'b0;
      link_addr_d  = link_addr_q;
      unique case (state_q)
         StBoot: state_d = StRun;
         StRun: begin
            if (taken && misaligned) begin
               state_d      = StFault;
               fault_d      = 1'b1;
               fault_addr_d = target;
            end else if (taken) begin
               // Redirect overrides stall and cancels any unaccepted request.
               pc_d = target;
               if (br_link_i) begin
                  link_valid_d = 1'b1;
                  link_addr_d  = br_pc_i + ADDR_W'(INSTR_BYTES);
               end
            end else if (fetch_ready_i && !stall_i) begin
               pc_d = pc_q + ADDR_W'(INSTR_BYTES);
            end
         end
         StFault: ;
         default: state_d = StBoot;
      endcase
   end

   assign fetch_valid_o = (state_q == StRun);
   assign fetch_addr_o  = pc_q;
   assign link_valid_o  = link_valid_q;
   assign link_addr_o   = link_addr_q;
   assign fault_o       = fault_q;
   assign fault_addr_o  = fault_addr_q;

`ifdef PC_PERF_COUNTERS_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] redir_cnt_q;
   logic        fetch_inc;
   logic        redir_inc;

   assign fetch_inc = (state_q == StRun) && !taken && fetch_ready_i && !stall_i;
   assign redir_inc = (state_q == StRun) && taken && !misaligned;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         if (fetch_inc) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (redir_inc) redir_cnt_q <= redir_cnt_q + 32'd1;
      end
   end

   assign fetch_count_o    = fetch_cnt_q;
   assign redirect_count_o = redir_cnt_q;
`else
   assign fetch_count_o    = '0;
   assign redirect_count_o = '0;
`endif

endmodule
